// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter : single-port memory sequencer shared by IF (fetch) and MA (load/store)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int MA_STREAK   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_rdata_o,
  input  logic        ma_is_ld_i,
  input  logic        ma_is_st_i,
  input  logic [31:0] ma_addr_i,
  input  logic [31:0] ma_wdata_i,
  output logic        ma_done_o,
  output logic [31:0] ma_ldresult_o,
  output logic        stall_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        proto_err_o
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [3:0] c_WAIT   = 4'(WAIT_STATES);
  localparam logic [3:0] c_STREAK = 4'(MA_STREAK);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        owner_ma_q, owner_ma_d;
  logic        if_done_q, if_done_d;
  logic        ma_done_q, ma_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ma_ldresult_q, ma_ldresult_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        proto_err_q, proto_err_d;

  logic w_ma_req;
  logic w_force_if;
  logic w_grant_ma;
  logic w_grant_if;
  logic w_ma_store;

  assign w_ma_req   = ma_is_ld_i | ma_is_st_i;
  // IF is pushed through once MA has won MA_STREAK times in a row against it
  assign w_force_if = if_req_i & w_ma_req & (streak_q == c_STREAK);
  assign w_grant_ma = w_ma_req & ~w_force_if;
  assign w_grant_if = if_req_i & ~w_grant_ma;
  assign w_ma_store = ma_is_st_i & ~ma_is_ld_i;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    streak_d      = if_req_i ? streak_q : 4'd0;
    owner_ma_d    = owner_ma_q;
    if_done_d     = 1'b0;
    ma_done_d     = 1'b0;
    if_rdata_d    = if_rdata_q;
    ma_ldresult_d = ma_ldresult_q;
    mem_en_d      = mem_en_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    proto_err_d   = proto_err_q;

    case (state_q)
      c_IDLE: begin
        if (w_grant_ma) begin
          state_d    = c_BUSY;
          cnt_d      = c_WAIT;
          owner_ma_d = 1'b1;
          mem_en_d   = 1'b1;
          mem_we_d   = w_ma_store;
          mem_addr_d = ma_addr_i;
          if (w_ma_store) mem_wdata_d = ma_wdata_i;
          if (ma_is_ld_i & ma_is_st_i) proto_err_d = 1'b1;
          if (if_req_i && streak_q < c_STREAK) streak_d = streak_q + 4'd1;
        end else if (w_grant_if) begin
          state_d    = c_BUSY;
          cnt_d      = c_WAIT;
          owner_ma_d = 1'b0;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          streak_d   = 4'd0;
        end
      end
      c_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d  = c_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_ma_q) begin
            ma_done_d = 1'b1;
            if (!mem_we_q) ma_ldresult_d = mem_rdata_i;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_DONE: state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= c_IDLE;
      cnt_q         <= 4'd0;
      streak_q      <= 4'd0;
      owner_ma_q    <= 1'b0;
      if_done_q     <= 1'b0;
      ma_done_q     <= 1'b0;
      if_rdata_q    <= 32'd0;
      ma_ldresult_q <= 32'd0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      streak_q      <= streak_d;
      owner_ma_q    <= owner_ma_d;
      if_done_q     <= if_done_d;
      ma_done_q     <= ma_done_d;
      if_rdata_q    <= if_rdata_d;
      ma_ldresult_q <= ma_ldresult_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign if_done_o     = if_done_q;
  assign if_rdata_o    = if_rdata_q;
  assign ma_done_o     = ma_done_q;
  assign ma_ldresult_o = ma_ldresult_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign proto_err_o   = proto_err_q;
  assign stall_o       = (if_req_i & ~if_done_q) | (w_ma_req & ~ma_done_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter : scoreboard bench, WAIT_STATES=1 main instance plus a WAIT_STATES=0 instance
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ma_ld = 1'b0, ma_st = 1'b0;
  logic [31:0] if_addr = '0, ma_addr = '0, ma_wdata = '0;
  logic        if_done, ma_done, stall, mem_en, mem_we, proto_err;
  logic [31:0] if_rdata, ma_ldresult, mem_addr, mem_wdata, mem_rdata;

  logic        z_if_req = 1'b0, z_zero = 1'b0;
  logic [31:0] z_if_addr = '0, z_zero32 = '0;
  logic        z_if_done, z_ma_done, z_stall, z_mem_en, z_mem_we, z_proto_err;
  logic [31:0] z_if_rdata, z_ma_ldresult, z_mem_addr, z_mem_wdata, z_mem_rdata;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {16'hF00D, a[15:0]};
  endfunction

  assign mem_rdata   = mem_model(mem_addr);
  assign z_mem_rdata = mem_model(z_mem_addr);

  mem_port_arbiter #(.WAIT_STATES(1), .MA_STREAK(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_rdata_o(if_rdata),
    .ma_is_ld_i(ma_ld), .ma_is_st_i(ma_st), .ma_addr_i(ma_addr), .ma_wdata_i(ma_wdata),
    .ma_done_o(ma_done), .ma_ldresult_o(ma_ldresult), .stall_o(stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .proto_err_o(proto_err)
  );

  mem_port_arbiter #(.WAIT_STATES(0), .MA_STREAK(4)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(z_if_req), .if_addr_i(z_if_addr), .if_done_o(z_if_done), .if_rdata_o(z_if_rdata),
    .ma_is_ld_i(z_zero), .ma_is_st_i(z_zero), .ma_addr_i(z_zero32), .ma_wdata_i(z_zero32),
    .ma_done_o(z_ma_done), .ma_ldresult_o(z_ma_ldresult), .stall_o(z_stall),
    .mem_en_o(z_mem_en), .mem_we_o(z_mem_we), .mem_addr_o(z_mem_addr), .mem_wdata_o(z_mem_wdata),
    .mem_rdata_i(z_mem_rdata), .proto_err_o(z_proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_ma;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  // Scoreboard monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (ma_done && if_done) check("done_exclusive", 32'(ma_done & if_done), 32'd0);
    if (ma_done || if_done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got ma_done=%0b if_done=%0b required no done", ma_done, if_done);
      end else begin
        e = q.pop_front();
        check("grant_owner_is_ma", 32'(ma_done), 32'(e.is_ma));
        if (e.is_ma) check("ma_ldresult", ma_ldresult, e.data);
        else         check("if_rdata", if_rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (z_if_done || z_ma_done) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ws0_unexpected_done: got if_done=%0b ma_done=%0b required no done", z_if_done, z_ma_done);
      end else begin
        e = q0.pop_front();
        check("ws0_if_done_owner", 32'(z_if_done), 32'd1);
        check("ws0_if_rdata", z_if_rdata, e.data);
      end
    end
  end

  // Single MA access; called at a negedge, returns at the negedge where ma_done is high
  task automatic run_ma(input string name, input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_res, input logic exp_we);
    int lat = 0, en_cnt = 0, bad = 0;
    bit seen = 0;
    ma_ld = ld; ma_st = st; ma_addr = addr; ma_wdata = wdata;
    q.push_back('{is_ma: 1'b1, data: exp_res});
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        en_cnt++;
        if (mem_we !== exp_we || mem_addr !== addr) bad++;
        if (exp_we && mem_wdata !== wdata) bad++;
      end
      if (ma_done) seen = 1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_en_cycles"}, 32'(en_cnt), 32'd2);
    check({name, "_busy_stable"}, 32'(bad), 32'd0);
    check({name, "_stall_in_done"}, 32'(stall), 32'd0);
    ma_ld = 1'b0; ma_st = 1'b0;
  endtask

  initial begin
    int ndone, lat, bad_stall, bad_gap, last;
    bit seen;

    repeat (3) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_results", if_rdata | ma_ldresult, 32'd0);
    check("rst_flags", {28'd0, mem_we, if_done, ma_done, proto_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_ma("ld40", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);

    run_ma("st44", 1'b0, 1'b1, 32'h44, 32'h12345678, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("st_wdata_hold", mem_wdata, 32'h12345678);
    check("st_addr_hold", mem_addr, 32'h44);

    // Both requesters held: expect MA x4, IF, MA at one access per 4 cycles
    if_req = 1'b1; if_addr = 32'h100; ma_ld = 1'b1; ma_addr = 32'h40;
    for (int i = 0; i < 6; i++)
      q.push_back('{is_ma: (i != 4), data: (i == 4) ? 32'hF00D0100 : 32'hDEADBEEF});
    ndone = 0; lat = 0; bad_stall = 0; bad_gap = 0; last = 0;
    while (ndone < 6 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (!stall) bad_stall++;
      if (ma_done || if_done) begin
        if (ndone > 0 && (lat - last) != 4) bad_gap++;
        last = lat;
        ndone++;
      end
    end
    if_req = 1'b0; ma_ld = 1'b0;
    check("arb_done_count", 32'(ndone), 32'd6);
    check("arb_stall_held", 32'(bad_stall), 32'd0);
    check("arb_period", 32'(bad_gap), 32'd0);
    @(negedge clk);

    run_ma("proto", 1'b1, 1'b1, 32'h200, 32'hCAFE0000, 32'hF00D0200, 1'b0);
    check("proto_err_set", 32'(proto_err), 32'd1);
    @(negedge clk);
    run_ma("ld40b", 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
    check("proto_err_sticky", 32'(proto_err), 32'd1);
    @(negedge clk);

    // Reset in the second BUSY cycle aborts the access without a done pulse
    ma_ld = 1'b1; ma_addr = 32'h300;
    @(negedge clk);
    check("abort_busy1_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0; ma_ld = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_no_done", 32'(ma_done | if_done), 32'd0);
    check("abort_results", if_rdata | ma_ldresult, 32'd0);
    check("abort_proto_clr", 32'(proto_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_ma("ld300", 1'b1, 1'b0, 32'h300, 32'h0, 32'hF00D0300, 1'b0);
    @(negedge clk);

    // WAIT_STATES=0 instance: IF fetch completes two cycles after the request
    z_if_req = 1'b1; z_if_addr = 32'h500;
    q0.push_back('{is_ma: 1'b0, data: 32'hF00D0500});
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("ws0_stall_busy", 32'(z_stall), 32'd1);
      if (z_if_done) seen = 1;
    end
    check("ws0_latency", 32'(lat), 32'd2);
    check("ws0_stall_in_done", 32'(z_stall), 32'd0);
    z_if_req = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(q.size() + q0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion required finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
